// File: rtl/rdcla_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rdcla_seq_ctrl_pkg
// Shared definitions for the iterative recursive-doubling carry-lookahead
// adder: KPG code constants, controller state encoding and the propagate test.
//
// KPG encoding (2 bits per bit position):
//   2'b00 kill, 2'b11 generate, 2'b01 / 2'b10 propagate.
// -----------------------------------------------------------------------------
package rdcla_seq_ctrl_pkg;

    localparam logic [1:0] KPG_KILL = 2'b00;
    localparam logic [1:0] KPG_GEN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Propagate is the only code whose two bits differ.
    function automatic logic kpg_is_prop(input logic [1:0] code);
        return code[1] ^ code[0];
    endfunction

endpackage

// File: rtl/rdcla_kpg_step.sv
// -----------------------------------------------------------------------------
// rdcla_kpg_step
// One shared combine stage of the recursive-doubling carry-lookahead adder.
// For distance d = 2^dist_sel_i, a propagate code at position i >= d takes the
// code found at position i-d; kill and generate codes are never overwritten.
// Every candidate distance is computed per position and a select mux picks the
// one for the current pass.
//
// Ports:
//   kpg_i       in  2*WIDTH  KPG vector before the pass (pos i at [2i+1:2i])
//   dist_sel_i  in  SEL_W    log2 of the doubling distance for this pass
//   kpg_o       out 2*WIDTH  KPG vector after the pass
// -----------------------------------------------------------------------------
module rdcla_kpg_step
    import rdcla_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = $clog2(WIDTH),
    parameter int SEL_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic [2*WIDTH-1:0] kpg_i,
    input  logic [SEL_W-1:0]   dist_sel_i,
    output logic [2*WIDTH-1:0] kpg_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pos
        logic [1:0] cand_s [STAGES];
        logic [1:0] sel_s;

        for (genvar k = 0; k < STAGES; k++) begin : g_dist
            // Positions below the distance have no source and keep their code.
            if (i >= (1 << k)) begin : g_shift
                assign cand_s[k] = kpg_is_prop(kpg_i[2*i +: 2])
                                 ? kpg_i[2*(i - (1 << k)) +: 2]
                                 : kpg_i[2*i +: 2];
            end else begin : g_keep
                assign cand_s[k] = kpg_i[2*i +: 2];
            end
        end

        // Distance select mux for this position.
        always_comb begin
            sel_s = cand_s[0];
            for (int k = 1; k < STAGES; k++) begin
                sel_s = (dist_sel_i == SEL_W'(k)) ? cand_s[k] : sel_s;
            end
        end

        assign kpg_o[2*i +: 2] = sel_s;
    end

endmodule

// File: rtl/rdcla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rdcla_seq_ctrl
// Iterative sequencer for a recursive-doubling carry-lookahead adder. Accepts
// one operand pair, runs STAGES doubling passes through a single shared KPG
// combine stage, then resolves carries against carry-in and presents the sum.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair present
//   in_ready   out  high in IDLE only
//   a, b       in   WIDTH-bit operands (sampled only on the accept edge)
//   cin        in   carry-in (sampled only on the accept edge)
//   out_valid  out  high in DONE
//   out_ready  in   consumer accepts the result
//   sum        out  a+b+cin modulo 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   busy       out  high in ITER or DONE
//   ovf        out  signed overflow, only when RDCLA_OVF_EN is defined
//
// Build option: RDCLA_OVF_EN adds the ovf port and the operand sign registers.
// -----------------------------------------------------------------------------
module rdcla_seq_ctrl
    import rdcla_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef RDCLA_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] kpg_q, kpg_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic               cin_q, cin_d;
    logic [2*WIDTH-1:0] kpg_step_s;
    logic [2*WIDTH-1:0] kpg_init_s;
    logic [WIDTH-1:0]   resolved_s;
    logic [WIDTH-1:0]   carry_s;

    rdcla_kpg_step #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .SEL_W  (SEL_W)
    ) u_kpg_step (
        .kpg_i      (kpg_q),
        .dist_sel_i (cnt_q),
        .kpg_o      (kpg_step_s)
    );

    // Interleave operand bits into the initial KPG vector {a[i], b[i]}.
    always_comb begin
        kpg_init_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            kpg_init_s[2*i +: 2] = {a[i], b[i]};
        end
    end

    // Next-state logic: accept, doubling passes, result hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kpg_d   = kpg_q;
        p_d     = p_q;
        cin_d   = cin_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    kpg_d   = kpg_init_s;
                    p_d     = a ^ b;
                    cin_d   = cin;
                    cnt_d   = '0;
                    state_d = ST_ITER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ITER: begin
                kpg_d = kpg_step_s;
                cnt_d = cnt_q + SEL_W'(1);
                if (cnt_q == SEL_W'(STAGES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pass counter and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            kpg_q   <= '0;
            p_q     <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kpg_q   <= kpg_d;
            p_q     <= p_d;
            cin_q   <= cin_d;
        end
    end

    // Carry resolution: a propagate left after all passes reaches bit 0,
    // so it carries whatever the carry-in was.
    always_comb begin
        resolved_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (kpg_q[2*i +: 2] == KPG_GEN) begin
                resolved_s[i] = 1'b1;
            end else if (kpg_q[2*i +: 2] == KPG_KILL) begin
                resolved_s[i] = 1'b0;
            end else begin
                resolved_s[i] = cin_q;
            end
        end
    end

    assign carry_s   = {resolved_s[WIDTH-2:0], cin_q};
    assign sum       = p_q ^ carry_s;
    assign cout      = resolved_s[WIDTH-1];
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ITER) || (state_q == ST_DONE);

`ifdef RDCLA_OVF_EN
    logic a_msb_q;
    logic b_msb_q;

    // Operand sign bits captured on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && in_valid) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else begin
            a_msb_q <= a_msb_q;
            b_msb_q <= b_msb_q;
        end
    end

    assign ovf = out_valid && (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_rdcla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rdcla_seq_ctrl
// Directed bench for rdcla_seq_ctrl (WIDTH = 16). Define RDCLA_OVF_EN for both
// the RTL and this bench to also check the ovf port.
// -----------------------------------------------------------------------------
module tb_rdcla_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef RDCLA_OVF_EN
    logic        ovf;
`endif

    int total_cnt_r;
    int bad_cnt_r;

    rdcla_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef RDCLA_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt_r++;
        if (got !== exp) begin
            bad_cnt_r++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One operation: accept, measure latency, check result, hold for
    // hold_cycles of backpressure, then release.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] es,
                         input logic ec, input logic eo, input int hold_cycles);
        int n;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb; cin = tc;
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        chk("busy_iter", {31'd0, busy}, 32'd1);
        chk("iter_ready", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 32'd4);
        chk("sum", {16'd0, sum}, {16'd0, es});
        chk("cout", {31'd0, cout}, {31'd0, ec});
`ifdef RDCLA_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
`else
        if (eo !== 1'b0 && eo !== 1'b1) $display("note: unknown ovf expectation");
`endif
        for (int h = 0; h < hold_cycles; h++) begin
            in_valid = 1'b1; a = 16'h0F0F; b = 16'h0F0F; cin = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            chk("hold_sum", {16'd0, sum}, {16'd0, es});
            chk("hold_cout", {31'd0, cout}, {31'd0, ec});
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rel_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_valid", {31'd0, out_valid}, 32'd0);
        chk("rel_busy", {31'd0, busy}, 32'd0);
`ifdef RDCLA_OVF_EN
        chk("rel_ovf", {31'd0, ovf}, 32'd0);
`endif
    endtask

    initial begin
        total_cnt_r = 0;
        bad_cnt_r   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'd0;
        b         = 16'd0;
        cin       = 1'b0;
        out_ready = 1'b0;

        #12;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //     a         b         cin   sum       cout  ovf   hold
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'h00FF, 16'h0F0F, 1'b0, 16'h100E, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op(16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0, 1'b0, 0);
        // Backpressure: five cycles with out_ready low in DONE.
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5);

        // Reset while ITER is on its third pass (cnt = 2).
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total_cnt_r, bad_cnt_r);
        $finish;
    end

endmodule
